booth_seq_mul: RTL

- Iterative, parametrised Booth multiplier. Successor to the unrolled 8x8 combinational Booth array.
- Performs one add/sub-and-arithmetic-shift step per clock on a single shared step datapath.
- Supports signed or unsigned operands, selected per transaction.
- Sits behind a valid/ready handshake, so datapath blocks can issue a multiply and collect the 2*WIDTH-bit product later.

---
 rtl/booth_pkg.sv | 38 +++
 rtl/booth_step.sv | 62 ++++++
 rtl/booth_seq_mul.sv | 106 ++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// Radix-4 recoding is only used when BOOTH_RADIX4_EN is defined.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

    typedef enum logic [2:0] {
        ZERO,
        PM,
        P2M,
        NM,
        N2M
    } r4_t;

    function automatic r4_t r4_recode(input logic [2:0] bits);
        r4_t sel;
        case (bits)
            3'b001, 3'b010: sel = PM;
            3'b011:         sel = P2M;
            3'b100:         sel = N2M;
            3'b101, 3'b110: sel = NM;
            default:        sel = ZERO;
        endcase
        return sel;
    endfunction

    function automatic int step_count(input int width, input bit radix4);
        return radix4 ? (width + 2) / 2 : width + 2;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One Booth iteration: add/sub of the multiplicand, then arithmetic shift.
// Radix-2 by default; radix-4 (shift by 2) when BOOTH_RADIX4_EN is defined.
module booth_step
    import booth_pkg::*;
#(
    parameter int E = 18
) (
    input  logic [E-1:0] acc,
    input  logic [E-1:0] q,
    input  logic         q_m1,
    input  logic [E-1:0] m,
    output logic [E-1:0] acc_next,
    output logic [E-1:0] q_next,
    output logic         q_m1_next
);

`ifdef BOOTH_RADIX4_EN
    // Two guard bits keep +/-2M and the running sum exact before the shift.
    logic [E+1:0] ax;
    logic [E+1:0] mx;
    logic [E+1:0] sum;
    r4_t          sel;

    assign ax  = {{2{acc[E-1]}}, acc};
    assign mx  = {{2{m[E-1]}}, m};
    assign sel = r4_recode({q[1:0], q_m1});

    always_comb begin
        sum = ax;
        unique case (sel)
            PM:      sum = ax + mx;
            P2M:     sum = ax + (mx << 1);
            NM:      sum = ax - mx;
            N2M:     sum = ax - (mx << 1);
            default: sum = ax;
        endcase
    end

    assign acc_next  = sum[E+1:2];
    assign q_next    = {sum[1:0], q[E-1:2]};
    assign q_m1_next = q[1];
`else
    logic [1:0]   pair;
    logic [E-1:0] sum;

    assign pair = {q[0], q_m1};

    always_comb begin
        sum = acc;
        unique case (pair)
            PAIR_SUB: sum = acc - m;
            PAIR_ADD: sum = acc + m;
            default:  sum = acc;
        endcase
    end

    assign acc_next  = {sum[E-1], sum[E-1:1]};
    assign q_next    = {sum[0], q[E-1:1]};
    assign q_m1_next = q[0];
`endif

endmodule

// File: rtl/booth_seq_mul.sv
// Iterative Booth multiplier behind valid/ready handshakes, signed or unsigned.
// Define BOOTH_RADIX4_EN for radix-4 recoding (half the steps).
module booth_seq_mul
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

`ifdef BOOTH_RADIX4_EN
    localparam bit RADIX4 = 1'b1;
`else
    localparam bit RADIX4 = 1'b0;
`endif

    localparam int E     = WIDTH + 2;
    localparam int CW    = $clog2(E + 1);
    localparam int STEPS = step_count(WIDTH, RADIX4);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    state_t        state;
    logic [E-1:0]  acc;
    logic [E-1:0]  q;
    logic [E-1:0]  m;
    logic          q_m1;
    logic [CW-1:0] cnt;

    logic [E-1:0]  acc_n;
    logic [E-1:0]  q_n;
    logic          q_m1_n;

    function automatic logic [E-1:0] ext(input logic [WIDTH-1:0] v,
                                         input logic s);
        return s ? {{2{v[WIDTH-1]}}, v} : {2'b00, v};
    endfunction

    booth_step #(
        .E(E)
    ) u_step (
        .acc       (acc),
        .q         (q),
        .q_m1      (q_m1),
        .m         (m),
        .acc_next  (acc_n),
        .q_next    (q_n),
        .q_m1_next (q_m1_n)
    );

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            q         <= '0;
            m         <= '0;
            q_m1      <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= '0;
                        q     <= ext(a, is_signed);
                        m     <= ext(b, is_signed);
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc  <= acc_n;
                    q    <= q_n;
                    q_m1 <= q_m1_n;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Product is the low 2*WIDTH bits of {A,Q}.
                        product   <= {acc_n[WIDTH-3:0], q_n};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
